// File: rtl/uart_sdram_cmd_seq.sv
// rtl/uart_sdram_cmd_seq.sv - UART command frame parser issuing single-word SDRAM reads/writes
module uart_sdram_cmd_seq #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [15:0]       mem_wr_data,
    input  logic [15:0]       mem_rd_data,
    input  logic              mem_rd_ready,
    input  logic              mem_wr_done,
    output logic              busy,
    output logic              drop
);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_PRE  = TMO_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT_MEM, S_TX_LOAD, S_TX_WAIT
    } state_t;

    state_t            r_state, w_next;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic              r_is_write;
    logic [1:0]        r_cnt;
    logic [23:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [TMO_W-1:0]  r_tmo;
    logic [15:0]       r_q;
    logic [1:0]        r_qlen;
    logic              r_guard;
    logic              w_strobe;
    logic              w_send;
    logic              w_is_cmd;

    // Strobes of the wrong type for the pending request are ignored.
    assign w_strobe = r_is_write ? mem_wr_done : mem_rd_ready;
    assign w_send   = (r_state == S_TX_LOAD) && !tx_busy;
    assign w_is_cmd = (r_rx_data == 8'h52) || (r_rx_data == 8'h57);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (r_rx_valid) w_next = w_is_cmd ? S_ADDR : S_TX_LOAD;
            S_ADDR:     if (r_rx_valid && r_cnt == 2'd2) w_next = r_is_write ? S_DATA : S_ISSUE;
            S_DATA:     if (r_rx_valid && r_cnt == 2'd1) w_next = S_ISSUE;
            S_ISSUE:    w_next = S_WAIT_MEM;
            S_WAIT_MEM: if (w_strobe || r_tmo == TMO_PRE) w_next = S_TX_LOAD;
            S_TX_LOAD:  if (!tx_busy) w_next = S_TX_WAIT;
            S_TX_WAIT:  if (!r_guard && !tx_busy) w_next = (r_qlen != 2'd0) ? S_TX_LOAD : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_is_write <= 1'b0;
            r_cnt      <= 2'd0;
            r_addr     <= 24'h0;
            r_wdata    <= 16'h0;
            r_tmo      <= '0;
            r_q        <= 16'h0;
            r_qlen     <= 2'd0;
            r_guard    <= 1'b0;
        end else begin
            r_rx_data  <= rx_data;
            r_rx_valid <= rx_valid;
            r_guard    <= w_send;
            case (r_state)
                S_IDLE: if (r_rx_valid) begin
                    r_is_write <= (r_rx_data == 8'h57);
                    r_cnt      <= 2'd0;
                    if (!w_is_cmd) begin
                        r_q    <= {8'h3F, 8'h00};
                        r_qlen <= 2'd1;
                    end
                end
                S_ADDR: if (r_rx_valid) begin
                    r_addr <= {r_addr[15:0], r_rx_data};
                    r_cnt  <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
                end
                S_DATA: if (r_rx_valid) begin
                    r_wdata <= {r_wdata[7:0], r_rx_data};
                    r_cnt   <= r_cnt + 2'd1;
                end
                S_ISSUE: r_tmo <= '0;
                S_WAIT_MEM: begin
                    if (r_tmo != TMO_LAST) r_tmo <= r_tmo + TMO_W'(1);
                    if (w_strobe) begin
                        r_q    <= r_is_write ? {8'h4B, 8'h00} : mem_rd_data;
                        r_qlen <= r_is_write ? 2'd1 : 2'd2;
                    end else if (r_tmo == TMO_PRE) begin
                        r_q    <= {8'h54, 8'h00};
                        r_qlen <= 2'd1;
                    end
                end
                S_TX_LOAD: if (w_send) begin
                    r_q    <= {r_q[7:0], 8'h00};
                    r_qlen <= r_qlen - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_send     = w_send;
        tx_data     = w_send ? r_q[15:8] : 8'h00;
        mem_rd_req  = (r_state == S_ISSUE) && !r_is_write;
        mem_wr_req  = (r_state == S_ISSUE) && r_is_write;
        mem_addr    = r_addr[ADDR_W-1:0];
        mem_wr_data = r_wdata;
        busy        = (r_state != S_IDLE);
        drop        = r_rx_valid && (r_state == S_ISSUE || r_state == S_WAIT_MEM ||
                                     r_state == S_TX_LOAD || r_state == S_TX_WAIT);
    end
endmodule

// File: tb/tb_uart_sdram_cmd_seq.sv
// tb/tb_uart_sdram_cmd_seq.sv - directed bench for uart_sdram_cmd_seq
module tb_uart_sdram_cmd_seq;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic [23:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [15:0] mem_wr_data;
    logic [15:0] mem_rd_data;
    logic        mem_rd_ready;
    logic        mem_wr_done;
    logic        busy;
    logic        drop;

    uart_sdram_cmd_seq #(.ADDR_W(24), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_ready(mem_rd_ready), .mem_wr_done(mem_wr_done),
        .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_q[$];
    int tx_cyc = 0, rd_cnt = 0, wr_cnt = 0, drop_cnt = 0, dbl_cnt = 0;
    logic p_tx = 1'b0, p_rd = 1'b0, p_wr = 1'b0;

    always @(negedge clk) begin
        if (tx_send) begin
            tx_q.push_back(tx_data);
            tx_cyc = cyc;
        end
        if (mem_rd_req) rd_cnt++;
        if (mem_wr_req) wr_cnt++;
        if (drop) drop_cnt++;
        if ((tx_send && p_tx) || (mem_rd_req && p_rd) || (mem_wr_req && p_wr)) dbl_cnt++;
        p_tx = tx_send;
        p_rd = mem_rd_req;
        p_wr = mem_wr_req;
    end

    function automatic logic [7:0] q_at(input int i);
        if (tx_q.size() > i) return tx_q[i];
        return 8'hxx;
    endfunction

    int last_cyc = 0;

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        last_cyc = cyc;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_req(input bit wr, output int c);
        bit seen = 1'b0;
        c = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wr ? mem_wr_req : mem_rd_req) begin
                seen = 1'b1;
                c = cyc;
            end
        end
        if (!seen) check("req_seen", 0, 1);
    endtask

    task automatic wait_idle(input int lim);
        bit idle = 1'b0;
        for (int i = 0; i < lim && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check("idle_reached", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {busy, tx_send, mem_rd_req, mem_wr_req, drop}, 0);
        check({tag, "_data"}, {tx_data, mem_wr_data}, 0);
        check({tag, "_addr"}, mem_addr, 0);
    endtask

    int rc, b_rd, b_wr, b_drop;

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;
        mem_rd_data = 16'h0; mem_rd_ready = 1'b0; mem_wr_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Read 0x000123 -> BEEF
        tx_q.delete(); b_rd = rd_cnt; b_wr = wr_cnt;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h01); send_byte(8'h23);
        wait_req(1'b0, rc);
        check("rd_latency", rc - last_cyc, 2);
        check("rd_addr", mem_addr, 24'h000123);
        repeat (5) @(posedge clk);
        #1 mem_rd_data = 16'hBEEF; mem_rd_ready = 1'b1;
        @(posedge clk);
        #1 mem_rd_ready = 1'b0;
        wait_idle(100);
        check("rd_ntx", tx_q.size(), 2);
        check("rd_b0", q_at(0), 8'hBE);
        check("rd_b1", q_at(1), 8'hEF);
        check("rd_nreq", rd_cnt - b_rd, 1);
        check("rd_nowr", wr_cnt - b_wr, 0);

        // Write 0x123456 <- CAFE
        tx_q.delete(); b_rd = rd_cnt; b_wr = wr_cnt;
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        send_byte(8'hCA); send_byte(8'hFE);
        wait_req(1'b1, rc);
        check("wr_addr", mem_addr, 24'h123456);
        check("wr_data", mem_wr_data, 16'hCAFE);
        repeat (3) @(posedge clk);
        #1 mem_wr_done = 1'b1;
        @(posedge clk);
        #1 mem_wr_done = 1'b0;
        wait_idle(100);
        check("wr_ntx", tx_q.size(), 1);
        check("wr_b0", q_at(0), 8'h4B);
        check("wr_nreq", wr_cnt - b_wr, 1);

        // Bad opcode
        tx_q.delete(); b_rd = rd_cnt; b_wr = wr_cnt;
        send_byte(8'h41);
        repeat (2) @(posedge clk);
        wait_idle(100);
        check("bad_ntx", tx_q.size(), 1);
        check("bad_b0", q_at(0), 8'h3F);
        check("bad_noreq", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0);

        // Timeout, then a late strobe in IDLE
        tx_q.delete(); b_rd = rd_cnt;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        wait_req(1'b0, rc);
        check("tmo_addr", mem_addr, 24'h000010);
        wait_idle(TMO + 50);
        check("tmo_ntx", tx_q.size(), 1);
        check("tmo_b0", q_at(0), 8'h54);
        check("tmo_latency", tx_cyc - rc, TMO);
        @(posedge clk);
        #1 mem_rd_data = 16'h7777; mem_rd_ready = 1'b1;
        @(posedge clk);
        #1 mem_rd_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("late_ntx", tx_q.size(), 1);
        check("late_busy", busy, 0);

        // Overrun during WAIT_MEM, then tx backpressure
        tx_q.delete(); b_rd = rd_cnt; b_drop = drop_cnt;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_req(1'b0, rc);
        @(posedge clk);
        #1 send_byte(8'h52);
        tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_rd_data = 16'h1234; mem_rd_ready = 1'b1;
        @(posedge clk);
        #1 mem_rd_ready = 1'b0;
        repeat (200) @(posedge clk);
        #1 check("bp_held", tx_q.size(), 0);
        check("bp_busy", busy, 1);
        tx_busy = 1'b0;
        wait_idle(100);
        check("ovr_drop", drop_cnt - b_drop, 1);
        check("bp_ntx", tx_q.size(), 2);
        check("bp_b0", q_at(0), 8'h12);
        check("bp_b1", q_at(1), 8'h34);
        repeat (5) @(negedge clk);
        check("ovr_nreq", rd_cnt - b_rd, 1);
        check("ovr_idle", busy, 0);

        // Reset mid-frame, then a normal frame
        @(posedge clk);
        #1 send_byte(8'h52);
        send_byte(8'h00);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1 rst = 1'b0;
        tx_q.delete(); b_rd = rd_cnt;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        wait_req(1'b0, rc);
        check("post_addr", mem_addr, 24'h000001);
        @(posedge clk);
        #1 mem_rd_data = 16'h5AA5; mem_rd_ready = 1'b1;
        @(posedge clk);
        #1 mem_rd_ready = 1'b0;
        wait_idle(100);
        check("post_ntx", tx_q.size(), 2);
        check("post_b0", q_at(0), 8'h5A);
        check("post_b1", q_at(1), 8'hA5);
        check("post_nreq", rd_cnt - b_rd, 1);

        check("no_double_pulse", dbl_cnt, 0);
        check("total_wr", wr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
